// File: rtl/mpram_chk_pkg.sv
// Shared types and helpers for the multi-port RAM interface checker.
// Error codes, counter width and the read-pipe entry sizing helper.
package mpram_chk_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_DATA     = 3'd1,
        ERR_UNINIT   = 3'd2,
        ERR_WR_COLL  = 3'd3,
        ERR_ECC_DERR = 3'd4,
        ERR_SPUR_ECC = 3'd5
    } chk_err_e;

    // Packed width of a read-pipe entry {valid, known, addr, expected}.
    function automatic int unsigned rd_pipe_entry_w(input int unsigned aw, input int unsigned dw);
        return 2 + aw + dw;
    endfunction

    function automatic int unsigned port_w(input int unsigned nwr, input int unsigned nrd);
        int unsigned m;
        m = (nwr > nrd) ? nwr : nrd;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [7:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-7){1'b0}}, n};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/mpram_chk_rd_pipe.sv
// One read port of the checker: RD_LAT-deep expectation pipe plus the read-data compare.
// ECC-aware compare rules are enabled by MPRAM_CHK_ECC_EN.
module mpram_chk_rd_pipe
    import mpram_chk_pkg::*;
#(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_issue,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_exp,
    input  logic          i_known,
    input  logic [DW-1:0] i_rd_data,
    input  logic          i_ecccorr,
    input  logic          i_eccderr,
    output logic          o_cmp,
    output logic [AW-1:0] o_cmp_addr,
    output logic          o_evt,
    output chk_err_e      o_code
);

    typedef struct packed {
        logic          valid;
        logic          known;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
    } rd_pipe_entry_t;

    if ($bits(rd_pipe_entry_t) != rd_pipe_entry_w(AW, DW)) begin : g_bad_entry
        $error("rd_pipe_entry_t width does not match rd_pipe_entry_w");
    end

    rd_pipe_entry_t r_pipe [RD_LAT];
    rd_pipe_entry_t w_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < RD_LAT; s++) r_pipe[s] <= '0;
        end else begin
            r_pipe[0] <= '{valid: i_issue, known: i_known, addr: i_addr, exp: i_exp};
            for (int unsigned s = 1; s < RD_LAT; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign w_tail     = r_pipe[RD_LAT-1];
    assign o_cmp      = w_tail.valid;
    assign o_cmp_addr = w_tail.addr;

    always_comb begin
        o_evt  = 1'b0;
        o_code = ERR_NONE;
        if (w_tail.valid) begin
            if (!w_tail.known) begin
                o_evt  = 1'b1;
                o_code = ERR_UNINIT;
            end
`ifdef MPRAM_CHK_ECC_EN
            else if (i_eccderr) begin
                o_evt  = 1'b1;
                o_code = ERR_ECC_DERR;
            end else if (!i_ecccorr && (i_rd_data != w_tail.exp)) begin
                o_evt  = 1'b1;
                o_code = ERR_DATA;
            end
        end else if (i_ecccorr || i_eccderr) begin
            o_evt  = 1'b1;
            o_code = ERR_SPUR_ECC;
        end
`else
            else if (i_rd_data != w_tail.exp) begin
                o_evt  = 1'b1;
                o_code = ERR_DATA;
            end
        end
`endif
    end

`ifndef MPRAM_CHK_ECC_EN
    logic w_unused_ecc;
    assign w_unused_ecc = i_ecccorr | i_eccderr;
`endif

endmodule

// File: rtl/mpram_intf_checker.sv
// Passive multi-port RAM interface checker: shadow copy, written-bitmap and per-port read compare.
// Optional macro MPRAM_CHK_ECC_EN enables ecccorr/eccderr handling.
module mpram_intf_checker
    import mpram_chk_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 8,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned NWR        = 2,
    parameter  int unsigned NRD        = 2,
    parameter  int unsigned RD_LAT     = 1,
    parameter  int unsigned RDW_NEW    = 0,
    localparam int unsigned PW         = port_w(NWR, NRD)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NWR-1:0]            wr_cs,
    input  logic [NWR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NWR*DATA_WIDTH-1:0] wr_data,
    input  logic [NRD-1:0]            rd_cs,
    input  logic [NRD*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NRD*DATA_WIDTH-1:0] rd_data,
    input  logic [NRD-1:0]            ecccorr,
    input  logic [NRD-1:0]            eccderr,
    output logic                      chk_err,
    output logic [2:0]                chk_err_code,
    output logic [PW-1:0]             chk_err_port,
    output logic [CNT_W-1:0]          err_cnt,
    output logic [CNT_W-1:0]          chk_cnt
);

    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned DEPTH = 2**AW;

    logic [DW-1:0]    r_shadow [DEPTH];
    logic [DEPTH-1:0] r_written;

    logic             r_err;
    chk_err_e         r_code;
    logic [PW-1:0]    r_port;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_chk_cnt;

    logic [NWR-1:0]   w_coll;
    logic [DW-1:0]    w_exp [NRD];
    logic [NRD-1:0]   w_known;
    logic [NRD-1:0]   w_cmp;
    logic [AW-1:0]    w_cmp_addr [NRD];
    logic [NRD-1:0]   w_rd_evt;
    chk_err_e         w_rd_code [NRD];

    logic             w_any;
    chk_err_e         w_code;
    logic [PW-1:0]    w_port;
    logic [7:0]       w_nev;
    logic [7:0]       w_ncmp;

    // Shadow data is deliberately not reset; the bitmap decides what is tracked.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NWR; i++)
            if (wr_cs[i]) r_shadow[wr_addr[i*AW +: AW]] <= wr_data[i*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_written <= '0;
        end else begin
            for (int unsigned i = 0; i < NWR; i++)
                if (wr_cs[i]) r_written[wr_addr[i*AW +: AW]] <= 1'b1;
        end
    end

    always_comb begin
        w_coll = '0;
        for (int unsigned i = 1; i < NWR; i++)
            for (int unsigned k = 0; k < i; k++)
                if (wr_cs[i] && wr_cs[k] && (wr_addr[i*AW +: AW] == wr_addr[k*AW +: AW]))
                    w_coll[i] = 1'b1;
    end

    // Expectation captured at issue; same-cycle write forwarding honours highest port.
    always_comb begin
        for (int unsigned j = 0; j < NRD; j++) begin
            w_exp[j]   = r_shadow[rd_addr[j*AW +: AW]];
            w_known[j] = r_written[rd_addr[j*AW +: AW]];
            if (RDW_NEW != 0) begin
                for (int unsigned i = 0; i < NWR; i++) begin
                    if (wr_cs[i] && (wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW])) begin
                        w_exp[j]   = wr_data[i*DW +: DW];
                        w_known[j] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        mpram_chk_rd_pipe #(
            .AW     (AW),
            .DW     (DW),
            .RD_LAT (RD_LAT)
        ) u_pipe (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_issue    (rd_cs[j]),
            .i_addr     (rd_addr[j*AW +: AW]),
            .i_exp      (w_exp[j]),
            .i_known    (w_known[j]),
            .i_rd_data  (rd_data[j*DW +: DW]),
            .i_ecccorr  (ecccorr[j]),
            .i_eccderr  (eccderr[j]),
            .o_cmp      (w_cmp[j]),
            .o_cmp_addr (w_cmp_addr[j]),
            .o_evt      (w_rd_evt[j]),
            .o_code     (w_rd_code[j])
        );
    end

    // Scan from highest to lowest so the last hit is the reported (lowest) event.
    always_comb begin
        w_any  = 1'b0;
        w_code = ERR_NONE;
        w_port = '0;
        w_nev  = '0;
        w_ncmp = '0;
        for (int unsigned j = NRD; j > 0; j--) begin
            if (w_cmp[j-1]) w_ncmp = w_ncmp + 8'd1;
            if (w_rd_evt[j-1]) begin
                w_any  = 1'b1;
                w_code = w_rd_code[j-1];
                w_port = PW'(j-1);
                w_nev  = w_nev + 8'd1;
            end
        end
        for (int unsigned i = NWR; i > 0; i--) begin
            if (w_coll[i-1]) begin
                w_any  = 1'b1;
                w_code = ERR_WR_COLL;
                w_port = PW'(i-1);
                w_nev  = w_nev + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_code    <= ERR_NONE;
            r_port    <= '0;
            r_err_cnt <= '0;
            r_chk_cnt <= '0;
        end else begin
            r_err     <= w_any;
            r_code    <= w_code;
            r_port    <= w_port;
            r_err_cnt <= sat_add(r_err_cnt, w_nev);
            r_chk_cnt <= sat_add(r_chk_cnt, w_ncmp);
        end
    end

    assign chk_err      = r_err;
    assign chk_err_code = r_code;
    assign chk_err_port = r_port;
    assign err_cnt      = r_err_cnt;
    assign chk_cnt      = r_chk_cnt;

`ifndef SYNTHESIS
    bit verbose = 1'b0;
    always_ff @(posedge clk) begin
        if (verbose && rst_n) begin
            for (int unsigned i = 0; i < NWR; i++)
                if (wr_cs[i]) $info("wr%0d [%h] <= %h", i, wr_addr[i*AW +: AW], wr_data[i*DW +: DW]);
            for (int unsigned j = 0; j < NRD; j++) begin
                if (w_cmp[j]) $info("rd%0d compare [%h] data %h", j, w_cmp_addr[j], rd_data[j*DW +: DW]);
`ifdef MPRAM_CHK_ECC_EN
                if (w_cmp[j] && ecccorr[j]) $info("rd%0d corrected data accepted", j);
`endif
            end
            if (w_any) $info("error %s on port %0d", w_code.name(), w_port);
        end
    end
`endif

endmodule

// File: tb/tb_mpram_intf_checker.sv
// Directed bench for mpram_intf_checker with a queue-based reference model.
// Honours MPRAM_CHK_ECC_EN when defined for the whole build.
module tb_mpram_intf_checker;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NWR = 2;
    localparam int NRD = 2;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NWR-1:0]    wr_cs;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic [NRD-1:0]    rd_cs;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    ecccorr;
    logic [NRD-1:0]    eccderr;

    logic        chk_err,  n_chk_err;
    logic [2:0]  chk_err_code, n_chk_err_code;
    logic        chk_err_port, n_chk_err_port;
    logic [15:0] err_cnt,  n_err_cnt;
    logic [15:0] chk_cnt,  n_chk_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mpram_intf_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NWR(NWR), .NRD(NRD), .RD_LAT(RD_LAT), .RDW_NEW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_cs(wr_cs), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_cs(rd_cs), .rd_addr(rd_addr), .rd_data(rd_data), .ecccorr(ecccorr), .eccderr(eccderr),
        .chk_err(chk_err), .chk_err_code(chk_err_code), .chk_err_port(chk_err_port),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt)
    );

    mpram_intf_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NWR(NWR), .NRD(NRD), .RD_LAT(RD_LAT), .RDW_NEW(1)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .wr_cs(wr_cs), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_cs(rd_cs), .rd_addr(rd_addr), .rd_data(rd_data), .ecccorr(ecccorr), .eccderr(eccderr),
        .chk_err(n_chk_err), .chk_err_code(n_chk_err_code), .chk_err_port(n_chk_err_port),
        .err_cnt(n_err_cnt), .chk_cnt(n_chk_cnt)
    );

    // Reference model for the RDW_NEW=0 instance: issued reads wait in a queue until due.
    typedef struct { int unsigned due; logic [7:0] exp; bit known; } pend_t;
    pend_t       pq [NRD][$];
    pend_t       e_cur;
    logic [7:0]  m_mem [256];
    bit          m_known [256];
    int unsigned cyc = 0;
    int          nev, ncmp, fcode, fport, a_m;
    bit          coll;
    logic        m_err = 1'b0;
    logic [2:0]  m_code = 3'd0;
    logic        m_port = 1'b0;
    int          m_ecnt = 0;
    int          m_ccnt = 0;

    task automatic note(input int code, input int port);
        if (nev == 0) begin
            fcode = code;
            fport = port;
        end
        nev++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_err = 1'b0; m_code = 3'd0; m_port = 1'b0; m_ecnt = 0; m_ccnt = 0; cyc = 0;
            for (int a = 0; a < 256; a++) m_known[a] = 1'b0;
            for (int j = 0; j < NRD; j++) pq[j].delete();
        end else begin
            nev = 0; ncmp = 0; fcode = 0; fport = 0;
            cyc++;
            for (int i = 0; i < NWR; i++) begin
                coll = 1'b0;
                for (int k = 0; k < i; k++)
                    if (wr_cs[i] && wr_cs[k] && wr_addr[i*AW +: AW] == wr_addr[k*AW +: AW]) coll = 1'b1;
                if (coll) note(3, i);
            end
            for (int j = 0; j < NRD; j++) begin
                if (pq[j].size() != 0 && pq[j][0].due == cyc) begin
                    e_cur = pq[j].pop_front();
                    ncmp++;
                    if (!e_cur.known) note(2, j);
`ifdef MPRAM_CHK_ECC_EN
                    else if (eccderr[j]) note(4, j);
                    else if (!ecccorr[j] && rd_data[j*DW +: DW] !== e_cur.exp) note(1, j);
                end else if (ecccorr[j] || eccderr[j]) begin
                    note(5, j);
                end
`else
                    else if (rd_data[j*DW +: DW] !== e_cur.exp) note(1, j);
                end
`endif
            end
            for (int j = 0; j < NRD; j++) begin
                if (rd_cs[j]) begin
                    a_m = int'(rd_addr[j*AW +: AW]);
                    pq[j].push_back('{due: cyc + RD_LAT, exp: m_mem[a_m], known: m_known[a_m]});
                end
            end
            for (int i = 0; i < NWR; i++) begin
                if (wr_cs[i]) begin
                    a_m = int'(wr_addr[i*AW +: AW]);
                    m_mem[a_m]   = wr_data[i*DW +: DW];
                    m_known[a_m] = 1'b1;
                end
            end
            m_err  = (nev > 0);
            m_code = fcode[2:0];
            m_port = fport[0];
            m_ecnt = (m_ecnt + nev > 65535) ? 65535 : m_ecnt + nev;
            m_ccnt = (m_ccnt + ncmp > 65535) ? 65535 : m_ccnt + ncmp;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] lit);
        check({name, " dut"}, act, lit);
        check({name, " model"}, mdl, lit);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc chk_err", {31'd0, chk_err}, {31'd0, m_err});
            check("cyc chk_err_code", {29'd0, chk_err_code}, {29'd0, m_code});
            check("cyc chk_err_port", {31'd0, chk_err_port}, {31'd0, m_port});
            check("cyc err_cnt", {16'd0, err_cnt}, m_ecnt);
            check("cyc chk_cnt", {16'd0, chk_cnt}, m_ccnt);
        end
    end

    task automatic clear_in();
        wr_cs = '0; wr_addr = '0; wr_data = '0;
        rd_cs = '0; rd_addr = '0; rd_data = '0;
        ecccorr = '0; eccderr = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        clear_in();
    endtask

    task automatic wr(input int p, input logic [7:0] a, input logic [7:0] d);
        wr_cs[p] = 1'b1; wr_addr[p*AW +: AW] = a; wr_data[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input logic [7:0] a);
        rd_cs[p] = 1'b1; rd_addr[p*AW +: AW] = a;
    endtask

    task automatic ret(input int p, input logic [7:0] d);
        rd_data[p*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clear_in();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        pin("reset err_cnt", {16'd0, err_cnt}, m_ecnt, 0);
        pin("reset chk_cnt", {16'd0, chk_cnt}, m_ccnt, 0);
        pin("reset chk_err", {31'd0, chk_err}, {31'd0, m_err}, 0);
        rst_n = 1'b1;
        tick();

        // 1: independent writes then reads with correct data
        wr(0, 8'h10, 8'hAB); wr(1, 8'h14, 8'hCD); tick();
        rd(0, 8'h10); rd(1, 8'h14); tick();
        ret(0, 8'hAB); ret(1, 8'hCD); tick();
        pin("t1 chk_cnt", {16'd0, chk_cnt}, m_ccnt, 2);
        pin("t1 err_cnt", {16'd0, err_cnt}, m_ecnt, 0);
        pin("t1 chk_err", {31'd0, chk_err}, {31'd0, m_err}, 0);

        // 2: read of never-written address
        rd(0, 8'h33); tick();
        ret(0, 8'h00); tick();
        pin("t2 chk_err", {31'd0, chk_err}, {31'd0, m_err}, 1);
        pin("t2 code", {29'd0, chk_err_code}, {29'd0, m_code}, 2);
        pin("t2 port", {31'd0, chk_err_port}, {31'd0, m_port}, 0);
        pin("t2 err_cnt", {16'd0, err_cnt}, m_ecnt, 1);

        // 3: write collision, higher port wins
        wr(0, 8'h20, 8'h11); wr(1, 8'h20, 8'h22); tick();
        pin("t3 code", {29'd0, chk_err_code}, {29'd0, m_code}, 3);
        pin("t3 port", {31'd0, chk_err_port}, {31'd0, m_port}, 1);
        pin("t3 err_cnt", {16'd0, err_cnt}, m_ecnt, 2);
        rd(0, 8'h20); tick();
        ret(0, 8'h22); tick();
        pin("t3 rd chk_err", {31'd0, chk_err}, {31'd0, m_err}, 0);
        pin("t3 rd chk_cnt", {16'd0, chk_cnt}, m_ccnt, 4);

        // 4: data mismatch on read port 1, then same-cycle write+read
        wr(0, 8'h40, 8'h5A); tick();
        rd(1, 8'h40); tick();
        ret(1, 8'h5B); tick();
        pin("t4 code", {29'd0, chk_err_code}, {29'd0, m_code}, 1);
        pin("t4 port", {31'd0, chk_err_port}, {31'd0, m_port}, 1);
        pin("t4 err_cnt", {16'd0, err_cnt}, m_ecnt, 3);
        wr(0, 8'h41, 8'h77); rd(0, 8'h41); tick();
        ret(0, 8'h77); tick();
        pin("t4 rdw old code", {29'd0, chk_err_code}, {29'd0, m_code}, 2);
        pin("t4 rdw old err_cnt", {16'd0, err_cnt}, m_ecnt, 4);
        check("t4 rdw new chk_err", {31'd0, n_chk_err}, 0);
        check("t4 rdw new err_cnt", {16'd0, n_err_cnt}, 3);
        check("t4 rdw new chk_cnt", {16'd0, n_chk_cnt}, 6);

        // back-to-back reads on both ports
        rd(0, 8'h10); rd(1, 8'h14); tick();
        rd(0, 8'h14); rd(1, 8'h10); ret(0, 8'hAB); ret(1, 8'hCD); tick();
        rd(0, 8'h20); rd(1, 8'h40); ret(0, 8'hCD); ret(1, 8'hAB); tick();
        ret(0, 8'h22); ret(1, 8'h5A); tick();
        pin("b2b chk_cnt", {16'd0, chk_cnt}, m_ccnt, 12);
        pin("b2b err_cnt", {16'd0, err_cnt}, m_ecnt, 4);

        // 5: ECC flags with a read return and while idle
        rd(0, 8'h10); tick();
        ret(0, 8'hAB); eccderr[0] = 1'b1; tick();
`ifdef MPRAM_CHK_ECC_EN
        pin("t5 derr code", {29'd0, chk_err_code}, {29'd0, m_code}, 4);
        pin("t5 derr err_cnt", {16'd0, err_cnt}, m_ecnt, 5);
`else
        pin("t5 derr chk_err", {31'd0, chk_err}, {31'd0, m_err}, 0);
        pin("t5 derr err_cnt", {16'd0, err_cnt}, m_ecnt, 4);
`endif
        eccderr[1] = 1'b1; tick();
`ifdef MPRAM_CHK_ECC_EN
        pin("t5 spur code", {29'd0, chk_err_code}, {29'd0, m_code}, 5);
        pin("t5 spur port", {31'd0, chk_err_port}, {31'd0, m_port}, 1);
        pin("t5 spur err_cnt", {16'd0, err_cnt}, m_ecnt, 6);
`else
        pin("t5 spur chk_err", {31'd0, chk_err}, {31'd0, m_err}, 0);
        pin("t5 spur err_cnt", {16'd0, err_cnt}, m_ecnt, 4);
`endif

        // 6: reset with a read in flight
        wr(0, 8'h50, 8'h99); tick();
        rd(0, 8'h50); tick();
        #2 rst_n = 1'b0;
        ret(0, 8'h99); tick();
        pin("t6 in-reset err_cnt", {16'd0, err_cnt}, m_ecnt, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        pin("t6 post chk_cnt", {16'd0, chk_cnt}, m_ccnt, 0);
        pin("t6 post err_cnt", {16'd0, err_cnt}, m_ecnt, 0);
        rd(0, 8'h50); tick();
        ret(0, 8'h99); tick();
        pin("t6 code", {29'd0, chk_err_code}, {29'd0, m_code}, 2);
        pin("t6 port", {31'd0, chk_err_port}, {31'd0, m_port}, 0);
        pin("t6 err_cnt", {16'd0, err_cnt}, m_ecnt, 1);
        pin("t6 chk_cnt", {16'd0, chk_cnt}, m_ccnt, 1);

        tick(); tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
